conv_job_scheduler: RTL and testbench

- Sequences the binary 3x3 convolution core across multiple images held in the shared input/weight/output SRAMs.
- The host pushes job descriptors (input, weight and output base addresses) into a small FIFO.
- The scheduler launches the core once per job through its run/busy handshake and relocates the core's zero-based SRAM addresses by the active job's bases.
- It reports per-job completion and a job count to the host.

---
 rtl/conv_job_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_conv_job_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_job_scheduler.sv
// Job scheduler for the binary 3x3 convolution core: descriptor FIFO, launch FSM, SRAM address relocation.
// Define SCHED_TIMEOUT_EN to enable the start/run watchdogs that drive timeout_err.
module conv_job_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int START_WAIT     = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int ADDR_W         = 12
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_in_base,
  input  logic [ADDR_W-1:0] job_w_base,
  input  logic [ADDR_W-1:0] job_out_base,
  output logic              core_run,
  input  logic              core_busy,
  input  logic [ADDR_W-1:0] core_sram_read_address,
  input  logic [ADDR_W-1:0] core_wmem_read_address,
  input  logic [ADDR_W-1:0] core_sram_write_address,
  output logic [ADDR_W-1:0] sram_read_address,
  output logic [ADDR_W-1:0] wmem_read_address,
  output logic [ADDR_W-1:0] sram_write_address,
  output logic              sched_busy,
  output logic              job_done,
  output logic [7:0]        jobs_done,
  output logic              timeout_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      START_WAIT < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("conv_job_scheduler: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_RUN,
    S_RETIRE
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] in_base;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] out_base;
  } desc_t;

  state_e           state_q, state_d;
  desc_t            fifo_q [FIFO_DEPTH];
  desc_t            active_q, active_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             job_ready_q, job_ready_d;
  logic             core_run_q, core_run_d;
  logic             job_done_q, job_done_d;
  logic [7:0]       jobs_done_q, jobs_done_d;
  logic             go_retire;
  logic             push, pop;

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_MAX = (START_WAIT > TIMEOUT_CYCLES) ? START_WAIT : TIMEOUT_CYCLES;
  localparam int WD_W   = $clog2(WD_MAX + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_err_q, timeout_err_d;
`endif

  assign push = job_valid && job_ready_q;
  assign pop  = (state_q == S_RETIRE);

  // NOTE: descriptor storage has no reset; count_q gates every read, so stale entries are never used.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{in_base: job_in_base, w_base: job_w_base, out_base: job_out_base};
    end
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
    // Registered from next occupancy: a pop while full only reopens the FIFO one cycle later.
    job_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    core_run_d  = 1'b0;
    job_done_d  = 1'b0;
    jobs_done_d = jobs_done_q;
    go_retire   = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          active_d   = fifo_q[rd_ptr_q];
          state_d    = S_LAUNCH;
          core_run_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
`ifdef SCHED_TIMEOUT_EN
        // Counter holds cycles elapsed since the core_run cycle.
        wd_cnt_d = WD_W'(1);
`endif
      end
      S_WAIT_BUSY: begin
        if (core_busy) begin
          state_d = S_RUN;
`ifdef SCHED_TIMEOUT_EN
          wd_cnt_d = WD_W'(1);
        end else if (wd_cnt_q == WD_W'(START_WAIT - 1)) begin
          timeout_err_d = 1'b1;
          go_retire     = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
`endif
        end
      end
      S_RUN: begin
        if (!core_busy) begin
          go_retire = 1'b1;
`ifdef SCHED_TIMEOUT_EN
        end else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          go_retire     = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
`endif
        end
      end
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (go_retire) begin
      state_d     = S_RETIRE;
      job_done_d  = 1'b1;
      jobs_done_d = jobs_done_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      state_q     <= S_IDLE;
      active_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      job_ready_q <= 1'b0;
      core_run_q  <= 1'b0;
      job_done_q  <= 1'b0;
      jobs_done_q <= '0;
`ifdef SCHED_TIMEOUT_EN
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      job_ready_q <= job_ready_d;
      core_run_q  <= core_run_d;
      job_done_q  <= job_done_d;
      jobs_done_q <= jobs_done_d;
`ifdef SCHED_TIMEOUT_EN
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

`ifdef SCHED_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign job_ready  = job_ready_q;
  assign core_run   = core_run_q;
  assign job_done   = job_done_q;
  assign jobs_done  = jobs_done_q;
  assign sched_busy = (state_q != S_IDLE) || (count_q != '0);

  // Relocation wraps modulo 2^ADDR_W; the carry out is intentionally dropped.
  assign sram_read_address  = core_sram_read_address  + active_q.in_base;
  assign wmem_read_address  = core_wmem_read_address  + active_q.w_base;
  assign sram_write_address = core_sram_write_address + active_q.out_base;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Directed testbench for conv_job_scheduler with a behavioural core model driving core_busy.
module tb_conv_job_scheduler;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_b, job_valid, job_ready, core_run, sched_busy, job_done, timeout_err;
  logic              core_busy = 1'b0;
  logic [ADDR_W-1:0] job_in_base, job_w_base, job_out_base;
  logic [ADDR_W-1:0] core_sram_read_address, core_wmem_read_address, core_sram_write_address;
  logic [ADDR_W-1:0] sram_read_address, wmem_read_address, sram_write_address;
  logic [7:0]        jobs_done;

  int passed = 0;
  int total  = 0;

  // Core model knobs and observations (start delay 0 = busy never rises)
  int m_start_delay = 1;
  int m_busy_len    = 5;
  int run_pulses    = 0;
  int overlap       = 0;
  int wait_left     = 0;
  int busy_left     = 0;
  logic [3*ADDR_W-1:0] seen_q[$];

  conv_job_scheduler dut (
    .clk                     (clk),
    .reset_b                 (reset_b),
    .job_valid               (job_valid),
    .job_ready               (job_ready),
    .job_in_base             (job_in_base),
    .job_w_base              (job_w_base),
    .job_out_base            (job_out_base),
    .core_run                (core_run),
    .core_busy               (core_busy),
    .core_sram_read_address  (core_sram_read_address),
    .core_wmem_read_address  (core_wmem_read_address),
    .core_sram_write_address (core_sram_write_address),
    .sram_read_address       (sram_read_address),
    .wmem_read_address       (wmem_read_address),
    .sram_write_address      (sram_write_address),
    .sched_busy              (sched_busy),
    .job_done                (job_done),
    .jobs_done               (jobs_done),
    .timeout_err             (timeout_err)
  );

  // Core model: busy rises m_start_delay cycles after core_run, stays high m_busy_len cycles.
  initial begin : core_model
    forever begin
      @(negedge clk);
      if (reset_b === 1'b1) begin
        wait_left = 0;
        busy_left = 0;
        core_busy = 1'b0;
      end else begin
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) core_busy = 1'b0;
        end else if (wait_left > 0) begin
          wait_left--;
          if (wait_left == 0) begin
            core_busy = 1'b1;
            busy_left = m_busy_len;
            seen_q.push_back({sram_read_address, wmem_read_address, sram_write_address});
          end
        end
        if (core_run === 1'b1) begin
          run_pulses++;
          if (busy_left > 0 || wait_left > 0) overlap++;
          wait_left = m_start_delay;
        end
      end
    end
  end

  function automatic logic [ADDR_W-1:0] b_in(input int k);
    return ADDR_W'(256 * (k + 1));
  endfunction
  function automatic logic [ADDR_W-1:0] b_w(input int k);
    return ADDR_W'(16 * k + 8);
  endfunction
  function automatic logic [ADDR_W-1:0] b_out(input int k);
    return ADDR_W'(2048 + 32 * k);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_core_addr(input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] w,
                               input logic [ADDR_W-1:0] o);
    core_sram_read_address  = r;
    core_wmem_read_address  = w;
    core_sram_write_address = o;
  endtask

  task automatic push(input logic [ADDR_W-1:0] ib, input logic [ADDR_W-1:0] wb,
                      input logic [ADDR_W-1:0] ob);
    job_valid    = 1'b1;
    job_in_base  = ib;
    job_w_base   = wb;
    job_out_base = ob;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_b   = 1'b1;
    job_valid = 1'b0;
    repeat (2) tick();
    reset_b = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (job_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_b   = 1'b1;
    job_valid = 1'b0;
    set_core_addr('0, '0, '0);
    repeat (2) tick();
    total++; if (job_ready !== 1'b0) $display("FAIL reset_job_ready: got %b want 0", job_ready); else passed++;
    total++; if (core_run !== 1'b0) $display("FAIL reset_core_run: got %b want 0", core_run); else passed++;
    total++; if (sched_busy !== 1'b0) $display("FAIL reset_sched_busy: got %b want 0", sched_busy); else passed++;
    total++; if (job_done !== 1'b0) $display("FAIL reset_job_done: got %b want 0", job_done); else passed++;
    total++; if (jobs_done !== 8'd0) $display("FAIL reset_jobs_done: got %0d want 0", jobs_done); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else passed++;
    total++; if (sram_read_address !== 12'h000) $display("FAIL reset_sram_addr: got %h want 000", sram_read_address); else passed++;
    reset_b = 1'b0;
    tick();
    total++; if (job_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", job_ready); else passed++;
  endtask

  task automatic test_single();
    bit ok;
    int rb;
    do_reset();
    rb = run_pulses;
    m_start_delay = 1;
    m_busy_len    = 20;
    set_core_addr(12'h003, 12'h002, 12'h005);
    push(12'h100, 12'h010, 12'h800);
    total++; if (core_run !== 1'b0) $display("FAIL single_run_early: got %b want 0", core_run); else passed++;
    total++; if (sched_busy !== 1'b1) $display("FAIL single_sched_busy: got %b want 1", sched_busy); else passed++;
    tick();
    total++; if (core_run !== 1'b1) $display("FAIL single_run_latency: got %b want 1", core_run); else passed++;
    repeat (5) tick();
    total++; if (sram_read_address !== 12'h103) $display("FAIL single_sram_addr: got %h want 103", sram_read_address); else passed++;
    total++; if (wmem_read_address !== 12'h012) $display("FAIL single_wmem_addr: got %h want 012", wmem_read_address); else passed++;
    total++; if (sram_write_address !== 12'h805) $display("FAIL single_wr_addr: got %h want 805", sram_write_address); else passed++;
    wait_done(60, ok);
    total++; if (ok !== 1'b1) $display("FAIL single_done_timeout: got %b want 1", ok); else passed++;
    total++; if (jobs_done !== 8'd1) $display("FAIL single_jobs_done: got %0d want 1", jobs_done); else passed++;
    tick();
    total++; if (job_done !== 1'b0) $display("FAIL single_done_pulse: got %b want 0", job_done); else passed++;
    total++; if (sched_busy !== 1'b0) $display("FAIL single_idle: got %b want 0", sched_busy); else passed++;
    total++; if (run_pulses - rb !== 1) $display("FAIL single_run_count: got %0d want 1", run_pulses - rb); else passed++;
  endtask

  task automatic test_back_to_back();
    int rb, sb, n;
    logic [3*ADDR_W-1:0] exp;
    do_reset();
    rb = run_pulses;
    sb = seen_q.size();
    m_start_delay = 1;
    m_busy_len    = 5;
    set_core_addr(12'h001, 12'h002, 12'h003);
    for (int k = 0; k < 4; k++) begin
      total++; if (job_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b want 1", k, job_ready); else passed++;
      push(b_in(k), b_w(k), b_out(k));
    end
    total++; if (job_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", job_ready); else passed++;
    n = 0;
    for (int i = 0; i < 300 && n < 4; i++) begin
      tick();
      if (job_done === 1'b1) n++;
    end
    total++; if (n !== 4) $display("FAIL b2b_done_count: got %0d want 4", n); else passed++;
    total++; if (jobs_done !== 8'd4) $display("FAIL b2b_jobs_done: got %0d want 4", jobs_done); else passed++;
    total++; if (sched_busy !== 1'b1) $display("FAIL b2b_busy_in_retire: got %b want 1", sched_busy); else passed++;
    tick();
    total++; if (sched_busy !== 1'b0) $display("FAIL b2b_busy_fall: got %b want 0", sched_busy); else passed++;
    total++; if (run_pulses - rb !== 4) $display("FAIL b2b_run_count: got %0d want 4", run_pulses - rb); else passed++;
    total++; if (overlap !== 0) $display("FAIL b2b_overlap: got %0d want 0", overlap); else passed++;
    total++; if (seen_q.size() - sb !== 4) $display("FAIL b2b_seen_count: got %0d want 4", seen_q.size() - sb); else passed++;
    for (int k = 0; k < 4; k++) begin
      exp = {b_in(k) + 12'd1, b_w(k) + 12'd2, b_out(k) + 12'd3};
      total++; if (seen_q[sb + k] !== exp) $display("FAIL b2b_order_%0d: got %h want %h", k, seen_q[sb + k], exp); else passed++;
    end
  endtask

  task automatic test_full_boundary();
    bit ok;
    int rb, sb, n;
    logic [3*ADDR_W-1:0] exp;
    do_reset();
    rb = run_pulses;
    sb = seen_q.size();
    m_start_delay = 1;
    m_busy_len    = 6;
    set_core_addr('0, '0, '0);
    for (int k = 0; k < 4; k++) push(b_in(k), b_w(k), b_out(k));
    job_valid    = 1'b1;
    job_in_base  = b_in(4);
    job_w_base   = b_w(4);
    job_out_base = b_out(4);
    wait_done(100, ok);
    total++; if (ok !== 1'b1) $display("FAIL full_first_done: got %b want 1", ok); else passed++;
    total++; if (job_ready !== 1'b0) $display("FAIL full_ready_in_pop: got %b want 0", job_ready); else passed++;
    tick();
    total++; if (job_ready !== 1'b1) $display("FAIL full_ready_after_pop: got %b want 1", job_ready); else passed++;
    tick();
    total++; if (job_ready !== 1'b0) $display("FAIL full_refilled: got %b want 0", job_ready); else passed++;
    job_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 300 && n < 4; i++) begin
      tick();
      if (job_done === 1'b1) n++;
    end
    total++; if (jobs_done !== 8'd5) $display("FAIL full_jobs_done: got %0d want 5", jobs_done); else passed++;
    total++; if (run_pulses - rb !== 5) $display("FAIL full_run_count: got %0d want 5", run_pulses - rb); else passed++;
    for (int k = 0; k < 5; k++) begin
      exp = {b_in(k), b_w(k), b_out(k)};
      total++; if (seen_q[sb + k] !== exp) $display("FAIL full_order_%0d: got %h want %h", k, seen_q[sb + k], exp); else passed++;
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    m_start_delay = 1;
    m_busy_len    = 4;
    set_core_addr(12'h005, 12'h003, 12'h7FF);
    push(12'hFFE, 12'hFFF, 12'h800);
    repeat (3) tick();
    total++; if (sram_read_address !== 12'h003) $display("FAIL wrap_sram_addr: got %h want 003", sram_read_address); else passed++;
    total++; if (wmem_read_address !== 12'h002) $display("FAIL wrap_wmem_addr: got %h want 002", wmem_read_address); else passed++;
    total++; if (sram_write_address !== 12'hFFF) $display("FAIL wrap_wr_addr: got %h want fff", sram_write_address); else passed++;
    wait_done(40, ok);
    total++; if (ok !== 1'b1) $display("FAIL wrap_done: got %b want 1", ok); else passed++;
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_watchdog();
    bit ok;
    int rb;
    do_reset();
    rb = run_pulses;
    m_start_delay = 0;
    m_busy_len    = 4;
    set_core_addr('0, '0, '0);
    push(b_in(0), b_w(0), b_out(0));
    push(b_in(1), b_w(1), b_out(1));
    total++; if (core_run !== 1'b1) $display("FAIL wd_first_run: got %b want 1", core_run); else passed++;
    m_start_delay = 1;
    repeat (7) tick();
    total++; if (timeout_err !== 1'b0) $display("FAIL wd_early: got %b want 0", timeout_err); else passed++;
    tick();
    total++; if (timeout_err !== 1'b1) $display("FAIL wd_start_timeout: got %b want 1", timeout_err); else passed++;
    total++; if (job_done !== 1'b1) $display("FAIL wd_retire: got %b want 1", job_done); else passed++;
    wait_done(40, ok);
    total++; if (ok !== 1'b1) $display("FAIL wd_next_done: got %b want 1", ok); else passed++;
    total++; if (timeout_err !== 1'b1) $display("FAIL wd_sticky: got %b want 1", timeout_err); else passed++;
    total++; if (jobs_done !== 8'd2) $display("FAIL wd_jobs_done: got %0d want 2", jobs_done); else passed++;
    total++; if (run_pulses - rb !== 2) $display("FAIL wd_run_count: got %0d want 2", run_pulses - rb); else passed++;
  endtask
`else
  task automatic test_no_watchdog();
    bit ok;
    do_reset();
    m_start_delay = 12;
    m_busy_len    = 4;
    set_core_addr('0, '0, '0);
    push(b_in(0), b_w(0), b_out(0));
    tick();
    total++; if (core_run !== 1'b1) $display("FAIL nowd_run: got %b want 1", core_run); else passed++;
    repeat (9) tick();
    total++; if (job_done !== 1'b0) $display("FAIL nowd_no_retire: got %b want 0", job_done); else passed++;
    total++; if (sched_busy !== 1'b1) $display("FAIL nowd_waiting: got %b want 1", sched_busy); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL nowd_err_wait: got %b want 0", timeout_err); else passed++;
    wait_done(40, ok);
    total++; if (ok !== 1'b1) $display("FAIL nowd_done: got %b want 1", ok); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL nowd_err_end: got %b want 0", timeout_err); else passed++;
    total++; if (jobs_done !== 8'd1) $display("FAIL nowd_jobs_done: got %0d want 1", jobs_done); else passed++;
  endtask
`endif

  task automatic test_reset_mid_run();
    int rb;
    do_reset();
    m_start_delay = 1;
    m_busy_len    = 30;
    set_core_addr('0, '0, '0);
    push(b_in(0), b_w(0), b_out(0));
    push(b_in(1), b_w(1), b_out(1));
    repeat (6) tick();
    rb = run_pulses;
    reset_b = 1'b1;
    tick();
    total++; if (job_ready !== 1'b0) $display("FAIL mid_job_ready: got %b want 0", job_ready); else passed++;
    total++; if (core_run !== 1'b0) $display("FAIL mid_core_run: got %b want 0", core_run); else passed++;
    total++; if (sched_busy !== 1'b0) $display("FAIL mid_sched_busy: got %b want 0", sched_busy); else passed++;
    total++; if (job_done !== 1'b0) $display("FAIL mid_job_done: got %b want 0", job_done); else passed++;
    total++; if (jobs_done !== 8'd0) $display("FAIL mid_jobs_done: got %0d want 0", jobs_done); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL mid_timeout_err: got %b want 0", timeout_err); else passed++;
    reset_b = 1'b0;
    repeat (40) tick();
    total++; if (run_pulses !== rb) $display("FAIL mid_no_relaunch: got %0d want %0d", run_pulses, rb); else passed++;
    total++; if (jobs_done !== 8'd0) $display("FAIL mid_jobs_after: got %0d want 0", jobs_done); else passed++;
    total++; if (sched_busy !== 1'b0) $display("FAIL mid_fifo_empty: got %b want 0", sched_busy); else passed++;
    total++; if (job_ready !== 1'b1) $display("FAIL mid_ready_after: got %b want 1", job_ready); else passed++;
  endtask

  initial begin
    reset_b      = 1'b1;
    job_valid    = 1'b0;
    job_in_base  = '0;
    job_w_base   = '0;
    job_out_base = '0;
    set_core_addr('0, '0, '0);
    test_reset();
    test_single();
    test_back_to_back();
    test_full_boundary();
    test_wrap();
`ifdef SCHED_TIMEOUT_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
